store_block: RTL and testbench



---
 rtl/store_pkg.sv | 13 +
 rtl/byte_lane_merge.sv | 21 ++
 rtl/store_block.sv | 59 +++++
 tb/tb_store_block.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared widths and select encodings for the RV32 store-data formatter.
// Everything that sizes a byte lane or decodes store_select comes from here.
package store_pkg;

  localparam int XLEN      = 32;
  localparam int BYTE_W    = 8;
  localparam int NUM_LANES = XLEN / BYTE_W;
  localparam int OFF_W     = $clog2(NUM_LANES);

  localparam logic SEL_SW = 1'b1;
  localparam logic SEL_SB = 1'b0;

endpackage

// File: rtl/byte_lane_merge.sv
// One byte lane of the SB read-modify-write merge.
// The lane index is fixed at elaboration; the lane is replaced only when the offset selects it.
module byte_lane_merge
  import store_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [BYTE_W-1:0] word_in,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic [OFF_W-1:0]  lane,
  output logic [BYTE_W-1:0] word_out,
  output logic              be
);

  logic hit;

  assign hit      = (lane == OFF_W'(LANE));
  assign word_out = hit ? byte_in : word_in;
  assign be       = hit;

endmodule

// File: rtl/store_block.sv
// Store-data formatter for SW/SB in the memory stage.
// SW passes rs2 through; SB merges one byte into the word already in memory. One-cycle registered output.
module store_block
  import store_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 store_valid,
  input  logic [XLEN-1:0]      Mem,
  input  logic [BYTE_W-1:0]    imm_byte,
  input  logic [OFF_W-1:0]     offset,
  input  logic                 store_select,
  input  logic [XLEN-1:0]      store_word,
  output logic [XLEN-1:0]      store_out,
  output logic [NUM_LANES-1:0] store_be,
  output logic                 out_valid
);

  logic [XLEN-1:0]      merged_word;
  logic [NUM_LANES-1:0] merged_be;
  logic [XLEN-1:0]      nxt_word;
  logic [NUM_LANES-1:0] nxt_be;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    byte_lane_merge #(.LANE(k)) u_merge (
      .word_in  (Mem[k*BYTE_W +: BYTE_W]),
      .byte_in  (imm_byte),
      .lane     (offset),
      .word_out (merged_word[k*BYTE_W +: BYTE_W]),
      .be       (merged_be[k])
    );
  end

  // The mux keeps the unused operand (Mem/imm_byte on SW, store_word on SB) off the output.
  always_comb begin
    nxt_word = merged_word;
    nxt_be   = merged_be;
    if (store_select == SEL_SW) begin
      nxt_word = store_word;
      nxt_be   = '1;
    end
  end

  // Reset drops any store in flight; otherwise data only moves when a store is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_out <= '0;
      store_be  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= store_valid;
      if (store_valid) begin
        store_out <= nxt_word;
        store_be  <= nxt_be;
      end
    end
  end

endmodule

// File: tb/tb_store_block.sv
// Scoreboard bench for store_block: the driver queues reference results, a negedge monitor pops and compares.
module tb_store_block;

  logic        clk;
  logic        rst;
  logic        store_valid;
  logic [31:0] Mem;
  logic [7:0]  imm_byte;
  logic [1:0]  offset;
  logic        store_select;
  logic [31:0] store_word;
  logic [31:0] store_out;
  logic [3:0]  store_be;
  logic        out_valid;

  int checks = 0;
  int errors = 0;
  logic [35:0] expQ[$];
  logic [31:0] heldOut;
  logic [3:0]  heldBe;
  bit          driveDone = 0;

  store_block dut (
    .clk          (clk),
    .rst          (rst),
    .store_valid  (store_valid),
    .Mem          (Mem),
    .imm_byte     (imm_byte),
    .offset       (offset),
    .store_select (store_select),
    .store_word   (store_word),
    .store_out    (store_out),
    .store_be     (store_be),
    .out_valid    (out_valid)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference: SW writes the register word; SB writes memory with one byte replaced.
  function automatic logic [35:0] refModel(input logic sel, input logic [31:0] mem,
                                           input logic [7:0] b, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] w;
    logic [3:0]  e;
    if (sel) begin
      w = word;
      e = 4'hF;
    end else begin
      w = mem;
      w[int'(off)*8 +: 8] = b;
      e = 4'(1 << off);
    end
    return {e, w};
  endfunction

  function automatic void checkOutput(input string name, input logic [31:0] gotOut,
                                      input logic [3:0] gotBe, input logic gotV,
                                      input logic [31:0] expOut, input logic [3:0] expBe,
                                      input logic expV);
    checks++;
    if (gotOut !== expOut || gotBe !== expBe || gotV !== expV) begin
      errors++;
      $display("[TB] FAIL %s: got out=%h be=%b valid=%b, expected out=%h be=%b valid=%b",
               name, gotOut, gotBe, gotV, expOut, expBe, expV);
    end
  endfunction

  task automatic applyStimulus(input logic v, input logic sel, input logic [31:0] mem,
                               input logic [7:0] b, input logic [1:0] off,
                               input logic [31:0] word);
    store_valid  = v;
    store_select = sel;
    Mem          = mem;
    imm_byte     = b;
    offset       = off;
    store_word   = word;
    @(posedge clk);
    if (v && !rst) expQ.push_back(refModel(sel, mem, b, off, word));
    #1;
  endtask

  // Monitor: a valid output must match the oldest queued store; otherwise outputs must hold.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      heldOut = '0;
      heldBe  = '0;
    end else if (out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", store_out, store_be, out_valid, heldOut, heldBe, 1'b0);
      end else begin
        logic [35:0] e;
        e = expQ.pop_front();
        checkOutput("store_result", store_out, store_be, out_valid, e[31:0], e[35:32], 1'b1);
        heldOut = e[31:0];
        heldBe  = e[35:32];
      end
    end else begin
      checkOutput(expQ.size() != 0 ? "latency" : "hold", store_out, store_be, out_valid,
                  heldOut, heldBe, 1'b0);
      expQ.delete();
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1;
    store_valid = 0; store_select = 0; Mem = 0; imm_byte = 0; offset = 0; store_word = 0;
    #1;
    checkOutput("reset_state", store_out, store_be, out_valid, 32'h0, 4'h0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    // SB into each lane of an all-ones word
    applyStimulus(1, 1'b0, 32'hFFFF_FFFF, 8'hAA, 2'd0, 32'hxxxx_xxxx);
    applyStimulus(1, 1'b0, 32'hFFFF_FFFF, 8'hAA, 2'd2, 32'hxxxx_xxxx);
    applyStimulus(1, 1'b0, 32'hFFFF_FFFF, 8'hAA, 2'd1, 32'hxxxx_xxxx);
    applyStimulus(1, 1'b0, 32'hFFFF_FFFF, 8'hAA, 2'd3, 32'hxxxx_xxxx);
    // Misaligned SW ignores offset and unused operands
    applyStimulus(1, 1'b1, 32'hFFFF_FFFF, 8'hAA, 2'd3, 32'h0000_00CC);
    applyStimulus(1, 1'b1, 32'hxxxx_xxxx, 8'hxx, 2'd1, 32'h1234_5678);
    applyStimulus(0, 1'b0, 32'h0, 8'h0, 2'd0, 32'h0);
    // Back-to-back SW then SB, then idle cycles that must hold
    applyStimulus(1, 1'b1, 32'h0, 8'h00, 2'd0, 32'hDEAD_BEEF);
    applyStimulus(1, 1'b0, 32'h0102_0304, 8'h5A, 2'd1, 32'hFFFF_FFFF);
    applyStimulus(0, 1'b1, 32'h0, 8'h0, 2'd0, 32'h7777_7777);
    applyStimulus(0, 1'b0, 32'h0, 8'h0, 2'd2, 32'h0);

    // Asynchronous reset mid-cycle with a store in flight
    applyStimulus(1, 1'b1, 32'h0, 8'h00, 2'd0, 32'hCAFE_F00D);
    #1 rst = 1;
    #1 checkOutput("async_reset", store_out, store_be, out_valid, 32'h0, 4'h0, 1'b0);
    store_valid = 1; store_select = 1; store_word = 32'h5555_AAAA;
    @(posedge clk); #1;
    checkOutput("reset_held", store_out, store_be, out_valid, 32'h0, 4'h0, 1'b0);
    store_valid = 0;
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(($urandom_range(0, 9) < 8), 1'($urandom), $urandom,
                    8'($urandom), 2'($urandom), $urandom);
    end
    applyStimulus(0, 1'b0, 32'h0, 8'h0, 2'd0, 32'h0);
    @(negedge clk); #1;

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d results still pending, expected 0", expQ.size());
    end
    driveDone = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
